inst_fetcher: RTL

Instruction fetch stage with an optional direct-mapped instruction cache. Maintains the architectural fetch PC, serves hits locally in one cycle, and on a miss issues a single fetch request to the memory controller, then waits for its completion pulse. Fetched instructions go to the decoder through a one-entry output register with stall backpressure. Jump/branch redirects from downstream replace the PC and squash any in-flight fetch.

---
 rtl/inst_fetcher_pkg.sv | 17 +
 rtl/inst_fetcher_icache.sv | 63 ++++++
 rtl/inst_fetcher.sv | 113 +++++++++++
 3 files changed

// File: rtl/inst_fetcher_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: none, declarations only.
// Backpressure: not applicable.
package inst_fetcher_pkg;

    localparam int   DEF_ADDR_LEN = 32;
    localparam int   DEF_INS_LEN  = 32;
    localparam int   ZERO_ADDR    = 0;
    localparam logic TRUE         = 1'b1;
    localparam logic FALSE        = 1'b0;

    typedef enum logic [1:0] {
        STATUS_IDLE = 2'd0,
        STATUS_WAIT = 2'd1
    } status_t;

endpackage

// File: rtl/inst_fetcher_icache.sv
// Direct-mapped instruction cache, one word per line; storage exists only with ICACHE_EN.
// Latency: combinational lookup, fill written at the clock edge.
// Backpressure: none; the fill port is a write strobe.
module inst_fetcher_icache
    import inst_fetcher_pkg::*;
#(
    parameter int LINES    = 64,
    parameter int ADDR_LEN = DEF_ADDR_LEN,
    parameter int INS_LEN  = DEF_INS_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_LEN-1:0] pc,
    output logic                hit,
    output logic [INS_LEN-1:0]  data,
    input  logic                fill_en,
    input  logic [ADDR_LEN-1:0] fill_addr,
    input  logic [INS_LEN-1:0]  fill_data
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_LEN - IDX_W - 2;

`ifdef ICACHE_EN
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [INS_LEN-1:0] data_q [LINES];
    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W-1:0]   wr_idx;
    logic               unused_low;

    assign rd_idx     = pc[IDX_W+1:2];
    assign wr_idx     = fill_addr[IDX_W+1:2];
    assign hit        = valid_q[rd_idx] && (tag_q[rd_idx] == pc[ADDR_LEN-1:IDX_W+2]);
    assign data       = data_q[rd_idx];
    // Byte offset never takes part in the lookup.
    assign unused_low = ^{pc[1:0], fill_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[wr_idx] <= TRUE;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[wr_idx]  <= fill_addr[ADDR_LEN-1:IDX_W+2];
            data_q[wr_idx] <= fill_data;
        end
    end
`else
    logic [IDX_W-1:0] unused_idx;
    logic             unused_all;

    assign hit        = FALSE;
    assign data       = '0;
    assign unused_idx = pc[IDX_W+1:2];
    assign unused_all = ^{clk, rst, pc, fill_en, fill_addr, fill_data, TAG_W[0]};
`endif

endmodule

// File: rtl/inst_fetcher.sv
// Fetch PC owner: hits served from the icache (ICACHE_EN), misses issue one memory request and wait.
// Latency: hit 1 cycle; miss ena_to_mem at T, valid_to_dec at T+k+1 after ok at T+k.
// Backpressure: one-entry output register held while stall_from_dec; no lookup while it cannot accept.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int ICACHE_LINES = 64,
    parameter int ADDR_LEN     = DEF_ADDR_LEN,
    parameter int INS_LEN      = DEF_INS_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    output logic                ena_to_mem,
    output logic [ADDR_LEN-1:0] pc_to_mem,
    input  logic                ok_flag_from_mem,
    input  logic [INS_LEN-1:0]  inst_from_mem,
    input  logic                stall_from_dec,
    output logic                valid_to_dec,
    output logic [INS_LEN-1:0]  inst_to_dec,
    output logic [ADDR_LEN-1:0] pc_to_dec,
    input  logic                jump_flag,
    input  logic [ADDR_LEN-1:0] target_pc
);

    status_t             state;
    logic [ADDR_LEN-1:0] pc;
    logic                discard;
    logic                cache_hit;
    logic [INS_LEN-1:0]  cache_data;
    logic                can_accept;
    logic                fill_en;

    assign can_accept = !valid_to_dec || !stall_from_dec;
    // A completion always fills the cache, even when a redirect drops the word.
    assign fill_en    = !rst && rdy && (state == STATUS_WAIT) && ok_flag_from_mem;

    inst_fetcher_icache #(
        .LINES    (ICACHE_LINES),
        .ADDR_LEN (ADDR_LEN),
        .INS_LEN  (INS_LEN)
    ) u_icache (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .hit       (cache_hit),
        .data      (cache_data),
        .fill_en   (fill_en),
        .fill_addr (pc_to_mem),
        .fill_data (inst_from_mem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= STATUS_IDLE;
            pc           <= ADDR_LEN'(ZERO_ADDR);
            discard      <= FALSE;
            ena_to_mem   <= FALSE;
            pc_to_mem    <= ADDR_LEN'(ZERO_ADDR);
            valid_to_dec <= FALSE;
            inst_to_dec  <= '0;
            pc_to_dec    <= ADDR_LEN'(ZERO_ADDR);
        end else if (rdy) begin
            ena_to_mem <= FALSE;
            if (valid_to_dec && !stall_from_dec) begin
                valid_to_dec <= FALSE;
            end
            if (jump_flag) begin
                pc           <= target_pc;
                valid_to_dec <= FALSE;
                if (state == STATUS_WAIT) begin
                    if (ok_flag_from_mem) begin
                        state   <= STATUS_IDLE;
                        discard <= FALSE;
                    end else begin
                        discard <= TRUE;
                    end
                end
            end else begin
                case (state)
                    STATUS_IDLE: begin
                        if (can_accept) begin
                            if (cache_hit) begin
                                inst_to_dec  <= cache_data;
                                pc_to_dec    <= pc;
                                valid_to_dec <= TRUE;
                                pc           <= pc + ADDR_LEN'(4);
                            end else begin
                                ena_to_mem <= TRUE;
                                pc_to_mem  <= pc;
                                state      <= STATUS_WAIT;
                            end
                        end
                    end
                    STATUS_WAIT: begin
                        if (ok_flag_from_mem) begin
                            state   <= STATUS_IDLE;
                            discard <= FALSE;
                            if (!discard) begin
                                inst_to_dec  <= inst_from_mem;
                                pc_to_dec    <= pc_to_mem;
                                valid_to_dec <= TRUE;
                                pc           <= pc + ADDR_LEN'(4);
                            end
                        end
                    end
                    default: state <= STATUS_IDLE;
                endcase
            end
        end
    end

endmodule
